// File: rtl/hbridge_multi_ctrl.sv
// Multi-channel L298N-style H-bridge driver with a shared PWM timebase, per-channel
// direction, coast dead time on reversal and active brake. Define HBRIDGE_RAMP_EN for soft ramps.
module hbridge_multi_ctrl #(
   parameter int CHANNELS   = 2,
   parameter int SPEED_W    = 8,
   parameter int PWM_PERIOD = 25000,
   parameter int RAMP_DIV   = 1000,
   parameter int DEAD_CYC   = 50000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [CHANNELS-1:0]           enable,
   input  logic [CHANNELS-1:0]           dir,
   input  logic [CHANNELS-1:0]           brake,
   input  logic [CHANNELS*SPEED_W-1:0]   speed,
   output logic [CHANNELS-1:0]           in1,
   output logic [CHANNELS-1:0]           in2,
   output logic [CHANNELS-1:0]           pwm_out,
   output logic [CHANNELS-1:0]           busy,
   output logic [CHANNELS*SPEED_W-1:0]   cur_speed
);

   localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int PROD_W = SPEED_W + CNT_W;
   localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

   localparam logic [SPEED_W-1:0] SPEED_MAX = '1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
   localparam logic [PROD_W-1:0]  PERIOD_P  = PROD_W'(PWM_PERIOD);
   localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_STOP  = 3'd2;
   localparam logic [2:0] ST_DEAD  = 3'd3;
   localparam logic [2:0] ST_BRAKE = 3'd4;

   logic [CNT_W-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pwm_cnt <= '0;
      else if (pwm_cnt == CNT_LAST)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 1'b1;
   end

`ifdef HBRIDGE_RAMP_EN
   localparam int RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [RDIV_W-1:0] ramp_cnt;
   logic              ramp_tick;

   assign ramp_tick = (ramp_cnt == RDIV_W'(RAMP_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ramp_cnt <= '0;
      else if (ramp_tick)
         ramp_cnt <= '0;
      else
         ramp_cnt <= ramp_cnt + 1'b1;
   end
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [2:0]         state, nxt_state;
      logic               dir_l, nxt_dir_l;
      logic               rev, nxt_rev;
      logic [SPEED_W-1:0] cur, nxt_cur, tgt;
      logic [DEAD_W-1:0]  dead_cnt, nxt_dead_cnt;
      logic [PROD_W-1:0]  thr;
      logic               in1_r, in2_r, pwm_r;

      assign tgt = speed[k*SPEED_W +: SPEED_W];
      // Full-width product so the duty threshold keeps every bit before the shift.
      assign thr = (PROD_W'(cur) * PERIOD_P) >> SPEED_W;

      always_comb begin
         nxt_state    = state;
         nxt_dir_l    = dir_l;
         nxt_rev      = rev;
         nxt_cur      = cur;
         nxt_dead_cnt = dead_cnt;
         case (state)
            ST_IDLE: begin
               nxt_cur = '0;
               if (brake[k])
                  nxt_state = ST_BRAKE;
               else if (enable[k]) begin
                  nxt_state = ST_RUN;
                  nxt_dir_l = dir[k];
               end
            end
            ST_RUN: begin
               if (brake[k])
                  nxt_state = ST_BRAKE;
               else if (!enable[k])
                  nxt_state = ST_STOP;
               else if (dir[k] != dir_l) begin
                  nxt_state = ST_STOP;
                  nxt_rev   = 1'b1;
               end else begin
`ifdef HBRIDGE_RAMP_EN
                  if (ramp_tick && (cur < tgt))
                     nxt_cur = cur + 1'b1;
                  else if (ramp_tick && (cur > tgt))
                     nxt_cur = cur - 1'b1;
`else
                  nxt_cur = tgt;
`endif
               end
            end
            ST_STOP: begin
               if (brake[k])
                  nxt_state = ST_BRAKE;
               else if (enable[k] && (dir[k] == dir_l) && !rev)
                  nxt_state = ST_RUN;
`ifdef HBRIDGE_RAMP_EN
               else if (cur == '0) begin
                  nxt_state    = rev ? ST_DEAD : ST_IDLE;
                  nxt_dead_cnt = '0;
               end else if (ramp_tick)
                  nxt_cur = cur - 1'b1;
`else
               else begin
                  nxt_cur      = '0;
                  nxt_state    = rev ? ST_DEAD : ST_IDLE;
                  nxt_dead_cnt = '0;
               end
`endif
            end
            ST_DEAD: begin
               // Direction is sampled only at the end, so toggles during coast do not restart it.
               if (brake[k])
                  nxt_state = ST_BRAKE;
               else if (dead_cnt == DEAD_LAST) begin
                  nxt_dir_l = dir[k];
                  nxt_rev   = 1'b0;
                  nxt_state = enable[k] ? ST_RUN : ST_IDLE;
               end else
                  nxt_dead_cnt = dead_cnt + 1'b1;
            end
            ST_BRAKE: begin
               if (!brake[k])
                  nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
         endcase
         if (nxt_state == ST_BRAKE) begin
            nxt_cur = '0;
            nxt_rev = 1'b0;
         end
      end

      // Pins are derived from the next state so they switch on the same edge as the FSM.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state    <= ST_IDLE;
            dir_l    <= 1'b0;
            rev      <= 1'b0;
            cur      <= '0;
            dead_cnt <= '0;
            in1_r    <= 1'b0;
            in2_r    <= 1'b0;
            pwm_r    <= 1'b0;
         end else begin
            state    <= nxt_state;
            dir_l    <= nxt_dir_l;
            rev      <= nxt_rev;
            cur      <= nxt_cur;
            dead_cnt <= nxt_dead_cnt;
            case (nxt_state)
               ST_RUN, ST_STOP: begin
                  in1_r <= nxt_dir_l;
                  in2_r <= ~nxt_dir_l;
                  pwm_r <= (cur == SPEED_MAX) || (PROD_W'(pwm_cnt) < thr);
               end
               ST_BRAKE: begin
                  in1_r <= 1'b1;
                  in2_r <= 1'b1;
                  pwm_r <= 1'b1;
               end
               default: begin
                  in1_r <= 1'b0;
                  in2_r <= 1'b0;
                  pwm_r <= 1'b0;
               end
            endcase
         end
      end

      assign in1[k]     = in1_r;
      assign in2[k]     = in2_r;
      assign pwm_out[k] = pwm_r;
      assign busy[k]    = (state == ST_STOP) || (state == ST_DEAD) ||
                          ((state == ST_RUN) && (cur != tgt));
      assign cur_speed[k*SPEED_W +: SPEED_W] = cur;
   end

endmodule

// File: tb/tb_hbridge_multi_ctrl.sv
// Self-checking bench for hbridge_multi_ctrl; expectations follow HBRIDGE_RAMP_EN if defined.
module tb_hbridge_multi_ctrl;

   localparam int CH   = 2;
   localparam int SW   = 8;
   localparam int PER  = 100;
   localparam int RDIV = 4;
   localparam int DEAD = 10;
`ifdef HBRIDGE_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif
   localparam int SETTLE = RAMP ? (256 * RDIV + 16) : 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [CH-1:0]     enable = '0;
   logic [CH-1:0]     dir = '0;
   logic [CH-1:0]     brake = '0;
   logic [CH*SW-1:0]  speed = '0;
   logic [CH-1:0]     in1, in2, pwm_out, busy;
   logic [CH*SW-1:0]  cur_speed;

   int total = 0;
   int bad   = 0;

   hbridge_multi_ctrl #(
      .CHANNELS(CH), .SPEED_W(SW), .PWM_PERIOD(PER), .RAMP_DIV(RDIV), .DEAD_CYC(DEAD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .dir(dir), .brake(brake),
      .speed(speed), .in1(in1), .in2(in2), .pwm_out(pwm_out), .busy(busy),
      .cur_speed(cur_speed)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic applyStimulus(input int ch, input logic en, input logic d, input logic b,
                                input logic [SW-1:0] s);
      enable[ch]          = en;
      dir[ch]             = d;
      brake[ch]           = b;
      speed[ch*SW +: SW]  = s;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] curOf(input int ch);
      return cur_speed[ch*SW +: SW];
   endfunction

   function automatic logic [2:0] pinsOf(input int ch);
      return {in1[ch], in2[ch], pwm_out[ch]};
   endfunction

   // Reference duty: high cycles per period = floor(s*PER/2^SW), full period at max speed.
   function automatic int expDuty(input int s);
      return (s == (1 << SW) - 1) ? PER : (s * PER) / (1 << SW);
   endfunction

   task automatic waitCur(input int ch, input logic [SW-1:0] tgt, output int n);
      n = 0;
      while (n < SETTLE && curOf(ch) !== tgt) begin
         stepClk();
         n++;
      end
   endtask

   task automatic measureDuty(input int ch, output int hi);
      hi = 0;
      repeat (2) stepClk();
      for (int i = 0; i < PER; i++) begin
         if (pwm_out[ch] === 1'b1) hi++;
         stepClk();
      end
   endtask

   initial begin
      int n, hi, d;
      logic [SW-1:0] s;
      logic [SW-1:0] fixed_spd [3];
      fixed_spd[0] = 8'd255;
      fixed_spd[1] = 8'd64;
      fixed_spd[2] = 8'd0;

      #3;
      checkOutput("reset_pins", {in1, in2, pwm_out, busy}, 0);
      checkOutput("reset_speed", cur_speed, 0);
      #9 reset_n = 1'b1;
      stepClk();

      $display("[TB] forward run to 128");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd128);
      stepClk();
      checkOutput("fwd_pins0", {in1[0], in2[0]}, 2'b10);
      waitCur(0, 8'd128, n);
      checkOutput("fwd_cur0", curOf(0), 128);
`ifdef HBRIDGE_RAMP_EN
      checkRange("fwd_ramp_time", n, 505, 516);
`else
      checkRange("fwd_load_time", n, 1, 1);
`endif
      stepClk();
      checkOutput("fwd_busy0", busy[0], 0);
      measureDuty(0, hi);
      checkOutput("fwd_duty0", hi, expDuty(128));

      $display("[TB] random speeds");
      for (int i = 0; i < 3; i++) begin
         s = 8'($urandom_range(1, 254));
         if (s == curOf(0)) s = s + 8'd1;
         applyStimulus(0, 1'b1, 1'b1, 1'b0, s);
         #1;
         checkOutput("rnd_busy0", busy[0], 1);
         waitCur(0, s, n);
         checkOutput("rnd_cur0", curOf(0), s);
         measureDuty(0, hi);
         checkOutput("rnd_duty0", hi, expDuty(int'(s)));
      end

      $display("[TB] boundary speeds");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b1, 1'b1, 1'b0, fixed_spd[i]);
         waitCur(0, fixed_spd[i], n);
         checkOutput("bnd_cur0", curOf(0), fixed_spd[i]);
         measureDuty(0, hi);
         checkOutput("bnd_duty0", hi, expDuty(int'(fixed_spd[i])));
      end

      $display("[TB] reversal");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd8);
      waitCur(0, 8'd8, n);
      checkOutput("rev_pre_cur0", curOf(0), 8);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'd8);
      n = 0;
      while (n < SETTLE && {in1[0], in2[0]} != 2'b00) begin
         stepClk();
         n++;
      end
`ifdef HBRIDGE_RAMP_EN
      checkRange("rev_stop_time", n, 28, 37);
`else
      checkRange("rev_stop_time", n, 2, 2);
`endif
      checkOutput("rev_cur0", curOf(0), 0);
      d = 0;
      while (d < 50 && in1[0] == 1'b0 && in2[0] == 1'b0) begin
         d++;
         stepClk();
      end
      checkOutput("rev_dead_len", d, DEAD);
      checkOutput("rev_pins0", {in1[0], in2[0]}, 2'b01);
      waitCur(0, 8'd8, n);
      checkOutput("rev_cur0_up", curOf(0), 8);

      $display("[TB] brake channel 1");
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'd100);
      repeat (RAMP ? 40 : 3) stepClk();
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 8'd100);
      stepClk();
      checkOutput("brk_pins1", pinsOf(1), 3'b111);
      checkOutput("brk_cur1", curOf(1), 0);
      checkOutput("brk_ch0_cur", curOf(0), 8);
      checkOutput("brk_ch0_pins", {in1[0], in2[0]}, 2'b01);
      repeat (5) stepClk();
      checkOutput("brk_hold1", pinsOf(1), 3'b111);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'd100);
      stepClk();
      checkOutput("brk_rel_idle1", pinsOf(1), 3'b000);
      stepClk();
      checkOutput("brk_rel_run1", {in1[1], in2[1]}, 2'b10);
      checkOutput("brk_rel_cur1", curOf(1), 0);
      waitCur(1, 8'd100, n);
      checkOutput("brk_rel_final1", curOf(1), 100);

      $display("[TB] reset mid-ramp");
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'd200);
      repeat (RAMP ? 30 : 1) stepClk();
      #3 reset_n = 1'b0;
      #1;
      checkOutput("rst_pins", {in1, in2, pwm_out, busy}, 0);
      checkOutput("rst_cur", cur_speed, 0);
      stepClk();
      stepClk();
      checkOutput("rst_hold_pins", {in1, in2, pwm_out}, 0);
      reset_n = 1'b1;
      stepClk();
      checkOutput("rst_restart_cur0", curOf(0), 0);
      checkOutput("rst_restart_pins0", {in1[0], in2[0]}, 2'b01);
      waitCur(0, 8'd200, n);
      checkOutput("rst_final_cur0", curOf(0), 200);
`ifdef HBRIDGE_RAMP_EN
      checkRange("rst_ramp_time", n, 790, 805);
`else
      checkRange("rst_load_time", n, 1, 1);
`endif

      $display("[TB] disable channel 0");
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'd200);
      waitCur(0, 8'd0, n);
      stepClk();
      stepClk();
      checkOutput("off_pins0", pinsOf(0), 3'b000);
      checkOutput("off_busy0", busy[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
